ahb_dbg_master: RTL and testbench

Debug bus initiator: turns a byte stream of read/write command frames into single-word AHB-Lite transfers, and returns status and read data as a byte stream. It is the AHB master counterpart of the peripheral slaves (UART, GPIO, timer). The byte side attaches to a UART receive/transmit pair, so a host can peek and poke the system bus over the serial link.

---
 rtl/ahb_dbg_master.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ahb_dbg_master.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_dbg_master.sv
// ---------------------------------------------------------------------------
// ahb_dbg_master
//   Debug bus initiator. Parses read/write command frames from a byte stream
//   (typically a UART receiver) and issues single-word AHB-Lite transfers.
//   Status and read data go back as a byte stream (typically to a UART
//   transmitter).
//
//   Frames (multi-byte fields MSB first):
//     write : 0x57 A3 A2 A1 A0 D3 D2 D1 D0   -> 0x4B
//     read  : 0x52 A3 A2 A1 A0               -> 0x4B D3 D2 D1 D0
//     bus error -> 0x45, data-phase timeout -> 0x54, bad opcode -> 0x3F
//
// Ports
//   hclk, hreset          clock, synchronous active-high reset
//   rx_valid_i/rx_data_i  command byte in; rx_ready_o accepts it
//   tx_valid_o/tx_data_o  response byte out; tx_ready_i consumes it
//   haddr_o .. hwdata_o   AHB-Lite master request signals
//   hrdata_i, hready_i,   AHB-Lite slave response signals
//   hresp_i
//   busy_o                high whenever a frame is in progress
// ---------------------------------------------------------------------------
module ahb_dbg_master #(
   parameter int unsigned AWIDTH  = 32,
   parameter int unsigned DWIDTH  = 32,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   output logic              rx_ready_o,
   output logic              tx_valid_o,
   output logic [7:0]        tx_data_o,
   input  logic              tx_ready_i,
   output logic [AWIDTH-1:0] haddr_o,
   output logic [1:0]        htrans_o,
   output logic              hwrite_o,
   output logic [2:0]        hsize_o,
   output logic [2:0]        hburst_o,
   output logic [DWIDTH-1:0] hwdata_o,
   input  logic [DWIDTH-1:0] hrdata_i,
   input  logic              hready_i,
   input  logic              hresp_i,
   output logic              busy_o
);

   // One extra bit so the counter can represent TIMEOUT without wrapping.
   localparam int unsigned   WW        = $clog2(TIMEOUT) + 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_OK   = 8'h4B;
   localparam logic [7:0] RSP_ERR  = 8'h45;
   localparam logic [7:0] RSP_TMO  = 8'h54;
   localparam logic [7:0] RSP_UNK  = 8'h3F;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_BUS_A,
      ST_BUS_D,
      ST_RESP
   } state_t;

   state_t            state_q,     state_d;
   logic              is_write_q,  is_write_d;
   logic [1:0]        byte_cnt_q,  byte_cnt_d;
   logic [31:0]       addr_q,      addr_d;
   logic [DWIDTH-1:0] wdata_q,     wdata_d;
   logic [AWIDTH-1:0] haddr_q,     haddr_d;
   logic [1:0]        htrans_q,    htrans_d;
   logic              hwrite_q,    hwrite_d;
   logic [DWIDTH-1:0] hwdata_q,    hwdata_d;
   logic [WW-1:0]     wait_q,      wait_d;
   logic [DWIDTH-1:0] rbuf_q,      rbuf_d;
   logic [2:0]        resp_left_q, resp_left_d;
   logic              tx_valid_q,  tx_valid_d;
   logic [7:0]        tx_data_q,   tx_data_d;
   logic              rx_ready_q,  rx_ready_d;

   logic rx_take;
   logic tx_take;

   // Word-aligned bus address from the 32-bit address field.
   function automatic logic [AWIDTH-1:0] word_addr(input logic [31:0] a);
      word_addr = AWIDTH'(a) & ~AWIDTH'(3);
   endfunction

   assign rx_take = rx_valid_i && rx_ready_q;
   assign tx_take = tx_valid_q && tx_ready_i;

   always_comb begin
      state_d     = state_q;
      is_write_d  = is_write_q;
      byte_cnt_d  = byte_cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      haddr_d     = haddr_q;
      htrans_d    = htrans_q;
      hwrite_d    = hwrite_q;
      hwdata_d    = hwdata_q;
      wait_d      = wait_q;
      rbuf_d      = rbuf_q;
      resp_left_d = resp_left_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;

      case (state_q)
         ST_IDLE: begin
            if (rx_take) begin
               byte_cnt_d = 2'd0;
               if (rx_data_i == OP_WRITE) begin
                  is_write_d = 1'b1;
                  state_d    = ST_ADDR;
               end else if (rx_data_i == OP_READ) begin
                  is_write_d = 1'b0;
                  state_d    = ST_ADDR;
               end else begin
                  state_d     = ST_RESP;
                  tx_valid_d  = 1'b1;
                  tx_data_d   = RSP_UNK;
                  resp_left_d = 3'd0;
               end
            end
         end

         ST_ADDR: begin
            if (rx_take) begin
               addr_d     = {addr_q[23:0], rx_data_i};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (is_write_q) begin
                     state_d = ST_WDATA;
                  end else begin
                     // Read: launch the address phase straight from the
                     // byte just received.
                     state_d  = ST_BUS_A;
                     htrans_d = HTRANS_NONSEQ;
                     haddr_d  = word_addr(addr_d);
                     hwrite_d = 1'b0;
                  end
               end
            end
         end

         ST_WDATA: begin
            if (rx_take) begin
               wdata_d    = {wdata_q[DWIDTH-9:0], rx_data_i};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d  = ST_BUS_A;
                  htrans_d = HTRANS_NONSEQ;
                  haddr_d  = word_addr(addr_q);
                  hwrite_d = 1'b1;
               end
            end
         end

         ST_BUS_A: begin
            if (hready_i) begin
               state_d  = ST_BUS_D;
               htrans_d = HTRANS_IDLE;
               wait_d   = '0;
               // Write data only moves on entry to the data phase; a read
               // leaves the previous value on the bus.
               if (is_write_q) begin
                  hwdata_d = wdata_q;
               end
            end
         end

         ST_BUS_D: begin
            if (hready_i) begin
               state_d    = ST_RESP;
               tx_valid_d = 1'b1;
               if (hresp_i) begin
                  tx_data_d   = RSP_ERR;
                  resp_left_d = 3'd0;
               end else begin
                  tx_data_d   = RSP_OK;
                  rbuf_d      = hrdata_i;
                  resp_left_d = is_write_q ? 3'd0 : 3'(DWIDTH / 8);
               end
            end else if (wait_q == WAIT_LAST) begin
               // This edge is wait state number TIMEOUT: give up.
               state_d     = ST_RESP;
               tx_valid_d  = 1'b1;
               tx_data_d   = RSP_TMO;
               resp_left_d = 3'd0;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end

         ST_RESP: begin
            if (tx_take) begin
               if (resp_left_q == 3'd0) begin
                  tx_valid_d = 1'b0;
                  state_d    = ST_IDLE;
               end else begin
                  tx_data_d   = rbuf_q[DWIDTH-1 -: 8];
                  rbuf_d      = {rbuf_q[DWIDTH-9:0], 8'h00};
                  resp_left_d = resp_left_q - 3'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) ||
                   (state_d == ST_WDATA);
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q     <= ST_IDLE;
         is_write_q  <= 1'b0;
         byte_cnt_q  <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         haddr_q     <= '0;
         htrans_q    <= HTRANS_IDLE;
         hwrite_q    <= 1'b0;
         hwdata_q    <= '0;
         wait_q      <= '0;
         rbuf_q      <= '0;
         resp_left_q <= '0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
         rx_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_write_q  <= is_write_d;
         byte_cnt_q  <= byte_cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         haddr_q     <= haddr_d;
         htrans_q    <= htrans_d;
         hwrite_q    <= hwrite_d;
         hwdata_q    <= hwdata_d;
         wait_q      <= wait_d;
         rbuf_q      <= rbuf_d;
         resp_left_q <= resp_left_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         rx_ready_q  <= rx_ready_d;
      end
   end

   assign rx_ready_o = rx_ready_q;
   assign tx_valid_o = tx_valid_q;
   assign tx_data_o  = tx_data_q;
   assign haddr_o    = haddr_q;
   assign htrans_o   = htrans_q;
   assign hwrite_o   = hwrite_q;
   assign hsize_o    = 3'b010;
   assign hburst_o   = 3'b000;
   assign hwdata_o   = hwdata_q;
   assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb_dbg_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_dbg_master
//   Drives command frames into ahb_dbg_master, models an AHB-Lite slave with
//   configurable wait states / error responses, and checks the response byte
//   stream against an expected-byte queue filled when each frame is issued.
// ---------------------------------------------------------------------------
module tb_ahb_dbg_master;

   localparam int unsigned TMO = 16;

   logic        hclk;
   logic        hreset;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        rx_ready_o;
   logic        tx_valid_o;
   logic [7:0]  tx_data_o;
   logic        tx_ready_i;
   logic [31:0] haddr_o;
   logic [1:0]  htrans_o;
   logic        hwrite_o;
   logic [2:0]  hsize_o;
   logic [2:0]  hburst_o;
   logic [31:0] hwdata_o;
   logic [31:0] hrdata_i;
   logic        hready_i;
   logic        hresp_i;
   logic        busy_o;

   ahb_dbg_master #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TMO)) dut (
      .hclk(hclk), .hreset(hreset),
      .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
      .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
      .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o),
      .hsize_o(hsize_o), .hburst_o(hburst_o), .hwdata_o(hwdata_o),
      .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i),
      .busy_o(busy_o)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] data;
      bit          err;
      int unsigned waits;
   } bus_t;

   bus_t        bus_q[$];
   logic [7:0]  exp_q[$];
   logic [31:0] bus_mem[16];
   logic [31:0] ref_mem[16];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          nonseq_cnt = 0;
   int          bus_issued = 0;
   bit          stall = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_haddr"},    haddr_o,    32'h0);
      check({tag, "_htrans"},   htrans_o,   2'b00);
      check({tag, "_hwrite"},   hwrite_o,   1'b0);
      check({tag, "_hwdata"},   hwdata_o,   32'h0);
      check({tag, "_tx_valid"}, tx_valid_o, 1'b0);
      check({tag, "_tx_data"},  tx_data_o,  8'h00);
      check({tag, "_busy"},     busy_o,     1'b0);
      check({tag, "_rx_ready"}, rx_ready_o, 1'b0);
      check({tag, "_hsize"},    hsize_o,    3'b010);
      check({tag, "_hburst"},   hburst_o,   3'b000);
   endtask

   // One byte on the command stream; returns 1 time unit after the edge
   // that accepted it.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int unsigned n;
      logic ok;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge hclk); #1; end
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 2000) begin
         @(negedge hclk);
         ok = rx_ready_o;
         @(posedge hclk);
         #1;
         n++;
      end
      if (!ok) fail_now("rx_accept_timeout");
      rx_valid_i = 1'b0;
   endtask

   // Reference model: decides the whole response of a frame from the frame
   // contents and the slave behaviour chosen for it.
   task automatic do_frame(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input bit err,
                           input int unsigned waits, input bit gaps);
      bus_t        t;
      logic [31:0] w;
      logic [7:0]  bytes[$];
      int unsigned hold;
      bytes = {op, addr[31:24], addr[23:16], addr[15:8], addr[7:0]};
      if (op == 8'h57) bytes = {bytes, data[31:24], data[23:16], data[15:8], data[7:0]};
      if (op != 8'h57 && op != 8'h52) begin
         bytes = {op};
         exp_q.push_back(8'h3F);
      end else begin
         t.addr  = {addr[31:2], 2'b00};
         t.write = (op == 8'h57);
         t.data  = data;
         t.err   = err;
         t.waits = waits;
         bus_q.push_back(t);
         bus_issued++;
         hold = err ? waits + 1 : waits;
         if (hold >= TMO) begin
            exp_q.push_back(8'h54);
         end else if (err) begin
            exp_q.push_back(8'h45);
         end else if (op == 8'h57) begin
            exp_q.push_back(8'h4B);
            ref_mem[addr[5:2]] = data;
         end else begin
            w = ref_mem[addr[5:2]];
            exp_q.push_back(8'h4B);
            exp_q.push_back(w[31:24]);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
         end
      end
      foreach (bytes[i]) send_byte(bytes[i], gaps);
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while ((exp_q.size() != 0 || bus_q.size() != 0 || busy_o) && n < 3000) begin
         @(negedge hclk);
         n++;
      end
      if (n >= 3000) fail_now("drain_timeout");
      repeat (4) @(posedge hclk);
      #1;
   endtask

   // AHB-Lite slave: one outstanding transfer, behaviour taken from bus_q.
   initial begin : slave
      bus_t        cur;
      bit          dp;
      int unsigned k;
      logic [31:0] cap;
      dp = 1'b0;
      k  = 0;
      cap = '0;
      hready_i = 1'b1;
      hresp_i  = 1'b0;
      hrdata_i = '0;
      forever begin
         @(posedge hclk);
         #1;
         hrdata_i = $urandom;
         if (hreset) begin
            dp = 1'b0;
            hready_i = 1'b1;
            hresp_i  = 1'b0;
         end else if (dp) begin
            hready_i = 1'b0;
            hresp_i  = 1'b0;
            if (htrans_o == 2'b10) begin
               nonseq_cnt++;
               fail_now("nonseq_in_data_phase");
            end
            if (cur.err) begin
               if (k == cur.waits) hresp_i = 1'b1;
               else if (k == cur.waits + 1) begin
                  hresp_i  = 1'b1;
                  hready_i = 1'b1;
                  dp = 1'b0;
               end
            end else if (k == cur.waits) begin
               hready_i = 1'b1;
               dp = 1'b0;
               if (cur.waits < TMO) begin
                  if (cur.write) begin
                     check("hwdata", hwdata_o, cur.data);
                     bus_mem[cap[5:2]] = hwdata_o;
                  end else begin
                     hrdata_i = bus_mem[cap[5:2]];
                  end
               end
            end
            k++;
         end else begin
            hready_i = 1'b1;
            hresp_i  = 1'b0;
            if (htrans_o == 2'b10) begin
               nonseq_cnt++;
               if (bus_q.size() == 0) begin
                  fail_now("nonseq_unexpected");
               end else begin
                  cur = bus_q.pop_front();
                  check("haddr",  haddr_o,  cur.addr);
                  check("hwrite", hwrite_o, cur.write);
                  check("hsize",  hsize_o,  3'b010);
                  check("hburst", hburst_o, 3'b000);
                  cap = haddr_o;
                  dp  = 1'b1;
                  k   = 0;
               end
            end
         end
      end
   end

   // Response consumer with random back-pressure.
   initial begin : tx_sink
      tx_ready_i = 1'b0;
      forever begin
         @(posedge hclk);
         #1;
         tx_ready_i = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops the expected byte whenever a response byte is consumed.
   initial begin : monitor
      logic       prev_stall;
      logic [7:0] prev_data;
      logic [7:0] e;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge hclk);
         if (hreset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("tx_hold_valid", tx_valid_o, 1'b1);
               check("tx_hold_data",  tx_data_o,  prev_data);
            end
            if (tx_valid_o && tx_ready_i) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL tx_unexpected: got %h required none at %0t", tx_data_o, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("tx_byte", tx_data_o, e);
               end
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data  = tx_data_o;
         end
      end
   end

   initial begin : watchdog
      repeat (60000) @(posedge hclk);
      fail_now("watchdog_expired");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : main
      logic [31:0] a;
      logic [31:0] d;
      logic [7:0]  op;
      int unsigned r;
      int unsigned w;
      int unsigned n;
      bit          e;
      rx_valid_i = 1'b0;
      rx_data_i  = '0;
      hreset     = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus_mem[i] = $urandom;
         ref_mem[i] = bus_mem[i];
      end
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      check_reset("rst");
      @(posedge hclk);
      #1;
      hreset = 1'b0;
      @(negedge hclk);
      check_reset("rst_rel");
      @(posedge hclk);
      #1;

      // Zero-wait write with cycle-exact latency checks.
      do_frame(8'h57, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
      @(negedge hclk);
      check("t1_htrans_nonseq", htrans_o, 2'b10);
      check("t1_haddr",         haddr_o,  32'h1000_0004);
      check("t1_hwrite",        hwrite_o, 1'b1);
      @(negedge hclk);
      check("t1_htrans_idle",   htrans_o, 2'b00);
      check("t1_hwdata",        hwdata_o, 32'hDEAD_BEEF);
      check("t1_tx_not_yet",    tx_valid_o, 1'b0);
      @(negedge hclk);
      check("t1_tx_valid",      tx_valid_o, 1'b1);
      check("t1_tx_first",      tx_data_o,  8'h4B);
      drain();
      check("t1_busy_low",      busy_o, 1'b0);

      // Read with three wait states; write data bus left alone.
      bus_mem[2] = 32'h1234_5678;
      ref_mem[2] = 32'h1234_5678;
      do_frame(8'h52, 32'h0000_0008, 32'h0, 1'b0, 3, 1'b0);
      drain();
      check("t2_hwdata_kept", hwdata_o, 32'hDEAD_BEEF);

      // Two-cycle error on a write, then a normal read.
      do_frame(8'h57, 32'h0000_0020, 32'h1122_3344, 1'b1, 0, 1'b0);
      do_frame(8'h52, 32'h0000_0020, 32'h0, 1'b0, 0, 1'b0);
      drain();

      // Timeout boundary: TMO-1 waits completes, TMO waits times out.
      do_frame(8'h52, 32'h0000_0030, 32'h0, 1'b0, TMO, 1'b0);
      do_frame(8'h57, 32'h0000_0034, 32'hCAFE_F00D, 1'b0, TMO - 1, 1'b0);
      do_frame(8'h52, 32'h0000_0034, 32'h0, 1'b0, 0, 1'b0);
      drain();

      // Unknown opcode and unaligned read address.
      do_frame(8'hAA, 32'h0, 32'h0, 1'b0, 0, 1'b0);
      do_frame(8'h52, 32'h0000_0007, 32'h0, 1'b0, 0, 1'b0);
      drain();

      // Response stalled for 10 cycles while a command byte is offered.
      stall = 1'b1;
      do_frame(8'h52, 32'h0000_0040, 32'h0, 1'b0, 1, 1'b0);
      n = 0;
      while (!tx_valid_o && n < 200) begin
         @(negedge hclk);
         n++;
      end
      if (n >= 200) fail_now("t6_tx_valid_timeout");
      rx_valid_i = 1'b1;
      rx_data_i  = 8'h52;
      repeat (10) begin
         @(negedge hclk);
         check("t6_rx_ready_low", rx_ready_o, 1'b0);
         check("t6_tx_valid",     tx_valid_o, 1'b1);
         check("t6_tx_data",      tx_data_o,  8'h4B);
      end
      @(posedge hclk);
      #1;
      rx_valid_i = 1'b0;
      stall = 1'b0;
      drain();

      // Reset after six bytes of a write frame.
      send_byte(8'h57, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h50, 1'b0);
      send_byte(8'hA5, 1'b0);
      hreset = 1'b1;
      @(posedge hclk);
      #1;
      @(negedge hclk);
      check_reset("t7_rst");
      @(posedge hclk);
      #1;
      hreset = 1'b0;
      @(negedge hclk);
      check_reset("t7_rel");
      @(posedge hclk);
      #1;
      do_frame(8'h57, 32'h0000_0050, 32'h0BAD_CAFE, 1'b0, 2, 1'b0);
      do_frame(8'h52, 32'h0000_0050, 32'h0, 1'b0, 0, 1'b0);
      drain();

      // Random back-to-back frames.
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         a = $urandom;
         d = $urandom;
         e = 1'b0;
         if (r == 0) begin
            do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
         end else begin
            op = (r < 5) ? 8'h57 : 8'h52;
         end
         r = $urandom_range(0, 9);
         if (r == 0) begin
            e = 1'b1;
            w = $urandom_range(0, 2);
         end else if (r == 1) begin
            w = TMO - 1;
         end else if (r == 2) begin
            w = $urandom_range(TMO, TMO + 2);
         end else begin
            w = $urandom_range(0, 3);
         end
         do_frame(op, a, d, e, w, 1'b1);
      end
      drain();

      check("nonseq_per_frame", nonseq_cnt, bus_issued);
      check("bus_q_empty", bus_q.size(), 0);
      check("exp_q_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
